muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID-stage decoder. It consumes the decoded HI/LO-write class (MULT, MULTU, DIV, DIVU) and the MTHI/MTLO moves, and owns the architectural HI and LO registers. While it is computing it asserts `busy`, which the hazard logic uses to stall the pipeline. An exception flush aborts it cleanly.

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO pair and stalls via busy.
// Define MULDIV_FAST_MULT_EN to swap the 32-cycle shift-add multiply for a single-cycle multiplier.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;

    logic [1:0]  stateQ, stateD;
    logic [4:0]  cntQ, cntD;
    logic [63:0] accQ, accD;
    logic [31:0] operandQ, operandD;
    logic        prodNegQ, prodNegD;
    logic        remNegQ, remNegD;
    logic [31:0] hiQ, hiD;
    logic [31:0] loQ, loD;
    logic        doneQ, doneD;

    logic        isIdle;
    logic        signedOp;
    logic        lastIter;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [63:0] mulNext;
    logic [63:0] mulFixed;
    logic [32:0] divTrial;
    logic [32:0] divDiff;
    logic [31:0] divRem;
    logic [63:0] divNext;
    logic [31:0] quotFixed;
    logic [31:0] remFixed;

    assign isIdle   = (stateQ == StIdle);
    assign busy     = !isIdle | (start & isIdle & !flush);
    assign done     = doneQ;
    assign hi       = hiQ;
    assign lo       = loQ;

    assign signedOp = !op[0];
    assign aMag     = (signedOp && a[31]) ? (~a + 32'd1) : a;
    assign bMag     = (signedOp && b[31]) ? (~b + 32'd1) : b;
    assign lastIter = (cntQ == 5'd31);

    // Multiply: operandQ holds the multiplicand magnitude, accQ[31:0] the multiplier magnitude.
`ifdef MULDIV_FAST_MULT_EN
    assign mulNext = {32'd0, operandQ} * {32'd0, accQ[31:0]};
`else
    logic [32:0] mulSum;
    assign mulSum  = {1'b0, accQ[63:32]} + (accQ[0] ? {1'b0, operandQ} : 33'd0);
    assign mulNext = {mulSum, accQ[31:1]};
`endif
    assign mulFixed = prodNegQ ? (~mulNext + 64'd1) : mulNext;

    // Restoring divide: accQ = {partial remainder, dividend bits shifting into quotient}.
    assign divTrial  = accQ[63:31];
    assign divDiff   = divTrial - {1'b0, operandQ};
    assign divRem    = divDiff[32] ? divTrial[31:0] : divDiff[31:0];
    assign divNext   = {divRem, accQ[30:0], ~divDiff[32]};
    assign quotFixed = prodNegQ ? (~divNext[31:0] + 32'd1) : divNext[31:0];
    assign remFixed  = remNegQ ? (~divNext[63:32] + 32'd1) : divNext[63:32];

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        accD     = accQ;
        operandD = operandQ;
        prodNegD = prodNegQ;
        remNegD  = remNegQ;
        hiD      = hiQ;
        loD      = loQ;
        doneD    = 1'b0;
        if (flush) begin
            stateD = StIdle;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (start) begin
                        prodNegD = signedOp & (a[31] ^ b[31]);
                        remNegD  = signedOp & a[31];
                        cntD     = 5'd0;
                        if (!op[1]) begin
                            stateD   = StMul;
                            accD     = {32'd0, bMag};
                            operandD = aMag;
                        end else if (b == 32'd0) begin
                            // Divide by zero: HI/LO keep their values, only signal completion.
                            doneD = 1'b1;
                        end else begin
                            stateD   = StDiv;
                            accD     = {32'd0, aMag};
                            operandD = bMag;
                        end
                    end else begin
                        if (mthi) begin
                            hiD = wdata;
                        end
                        if (mtlo) begin
                            loD = wdata;
                        end
                    end
                end
                StMul: begin
`ifdef MULDIV_FAST_MULT_EN
                    hiD    = mulFixed[63:32];
                    loD    = mulFixed[31:0];
                    doneD  = 1'b1;
                    stateD = StIdle;
`else
                    accD = mulNext;
                    cntD = cntQ + 5'd1;
                    if (lastIter) begin
                        hiD    = mulFixed[63:32];
                        loD    = mulFixed[31:0];
                        doneD  = 1'b1;
                        stateD = StIdle;
                    end
`endif
                end
                StDiv: begin
                    accD = divNext;
                    cntD = cntQ + 5'd1;
                    if (lastIter) begin
                        hiD    = remFixed;
                        loD    = quotFixed;
                        doneD  = 1'b1;
                        stateD = StIdle;
                    end
                end
                default: begin
                    stateD = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            cntQ     <= 5'd0;
            accQ     <= 64'd0;
            operandQ <= 32'd0;
            prodNegQ <= 1'b0;
            remNegQ  <= 1'b0;
            hiQ      <= 32'd0;
            loQ      <= 32'd0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            accQ     <= accD;
            operandQ <= operandD;
            prodNegQ <= prodNegD;
            remNegQ  <= remNegD;
            hiQ      <= hiD;
            loQ      <= loD;
            doneQ    <= doneD;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random operations against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = 33;
`endif

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // HI/LO after an operation, computed with plain 64-bit arithmetic ({HI, LO}).
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] prev);
        longint      sx;
        longint      sy;
        longint      sq;
        longint      sr;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] q;
        logic [63:0] r;
        logic [63:0] res;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        res = prev;
        case (o)
            2'b00: res = sx * sy;
            2'b01: res = ux * uy;
            2'b10: begin
                if (y != 32'd0) begin
                    sq = sx / sy;
                    sr = sx % sy;
                    q = sq;
                    r = sr;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y != 32'd0) begin
                    q = ux / uy;
                    r = ux % uy;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit injBusy, input bit injSame, input string tag);
        logic [63:0] expHiLo;
        int          expLat;
        int          busyCnt;
        int          doneAt;
        int          doneCnt;
        expHiLo = refModel(o, x, y, {modelHi, modelLo});
        expLat  = (o[1] && y == 32'd0) ? 1 : (o[1] ? 33 : MulLat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (injSame) begin
            mthi  = 1'b1;
            mtlo  = 1'b1;
            wdata = 32'hbad0bad0;
        end
        #1;
        busyCnt = busy ? 1 : 0;
        doneAt  = 0;
        doneCnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            a     = $urandom;
            b     = $urandom;
            if (injBusy && k == 5 && k < expLat) begin
                start = 1'b1;
                op    = ~o;
                mthi  = 1'b1;
                mtlo  = 1'b1;
                wdata = 32'hdeadbeef;
            end
            #1;
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (doneAt == 0) doneAt = k;
            end
        end
        modelHi = expHiLo[63:32];
        modelLo = expHiLo[31:0];
        check({tag, " busy cycles"}, busyCnt, expLat);
        check({tag, " done cycle"}, doneAt, expLat);
        check({tag, " done pulses"}, doneCnt, 1);
        check({tag, " hi"}, hi, modelHi);
        check({tag, " lo"}, lo, modelLo);
    endtask

    task automatic doMove(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        mthi  = h;
        mtlo  = l;
        wdata = d;
        #1;
        check("move busy", busy, 0);
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        #1;
        if (h) modelHi = d;
        if (l) modelLo = d;
        check("move hi", hi, modelHi);
        check("move lo", lo, modelLo);
        check("move done", done, 0);
    endtask

    initial begin
        int          doneCnt;
        int          doneAt;
        bit          seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp2;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        flush = 1'b0;
        modelHi = 32'd0;
        modelLo = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset done", done, 0);
        check("reset busy", busy, 0);

        // Directed cases from the test plan.
        runOp(2'b00, 32'hfffffffe, 32'h00000003, 1'b0, 1'b0, "mult signed");
        runOp(2'b01, 32'hffffffff, 32'hffffffff, 1'b0, 1'b0, "multu max");
        runOp(2'b10, 32'hfffffff9, 32'h00000002, 1'b0, 1'b0, "div neg");
        runOp(2'b11, 32'hffffffff, 32'h00000010, 1'b0, 1'b0, "divu");
        runOp(2'b10, 32'h80000000, 32'hffffffff, 1'b0, 1'b0, "div overflow");
        doMove(1'b1, 1'b1, 32'h11111111);
        doMove(1'b0, 1'b1, 32'h22222222);
        runOp(2'b10, 32'h00001234, 32'h00000000, 1'b0, 1'b0, "div by zero");
        runOp(2'b11, 32'h00001234, 32'h00000000, 1'b0, 1'b0, "divu by zero");
        doMove(1'b1, 1'b0, 32'h12345678);
        runOp(2'b00, 32'h00000007, 32'hfffffffd, 1'b1, 1'b0, "mult inject busy");
        runOp(2'b11, 32'h0000abcd, 32'h00000013, 1'b0, 1'b1, "divu with mtlo");

        // Flush on iteration 10 of DIVU.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'hffffffff;
        b     = 32'h00000010;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush busy low", busy, 0);
        doneCnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done) doneCnt++;
        end
        check("flush no done", doneCnt, 0);
        check("flush hi", hi, modelHi);
        check("flush lo", lo, modelLo);
        runOp(2'b01, 32'd3, 32'd5, 1'b0, 1'b0, "multu after flush");

        // Flush together with start in IDLE drops the start.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        a     = 32'd9;
        b     = 32'd9;
        #1;
        check("flush+start busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("flush+start idle", busy, 0);
        check("flush+start done", done, 0);
        check("flush+start lo", lo, modelLo);

        // Back-to-back: new start in the cycle that done is high.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd7;
        b     = 32'd9;
        seen  = 1'b0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) seen = 1'b1;
        end
        check("b2b first done", seen, 1);
        exp2 = refModel(2'b01, 32'd7, 32'd9, {modelHi, modelLo});
        modelHi = exp2[63:32];
        modelLo = exp2[31:0];
        check("b2b first lo", lo, modelLo);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'hffffff9c;
        b     = 32'd7;
        #1;
        check("b2b accept busy", busy, 1);
        doneAt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done && doneAt == 0) doneAt = k;
        end
        exp2 = refModel(2'b10, 32'hffffff9c, 32'd7, {modelHi, modelLo});
        modelHi = exp2[63:32];
        modelLo = exp2[31:0];
        check("b2b second done", doneAt, 33);
        check("b2b second hi", hi, modelHi);
        check("b2b second lo", lo, modelLo);

        // Random operations, moves and same-cycle/busy injections.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) doMove(1'($urandom), 1'($urandom), $urandom);
            runOp(ro, ra, rb, 1'($urandom), 1'($urandom), "random op");
        end

        // Reset mid-operation.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'h7fffffff;
        b     = 32'd3;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        modelHi = 32'd0;
        modelLo = 32'd0;
        check("mid reset busy", busy, 0);
        check("mid reset hi", hi, modelHi);
        check("mid reset lo", lo, modelLo);
        doneCnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done) doneCnt++;
        end
        check("mid reset no done", doneCnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
